serial_adder: RTL and testbench

Bit-serial adder that consumes one full_adder cell per clock. It adds two WIDTH-bit operands LSB-first over WIDTH cycles, using a registered carry between bit slices. It sits downstream of the full_adder, which it instantiates as its single combinational slice. It is the sequential counterpart to the ripple Add16 in the Hack ALU datapath.

---
 rtl/serial_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single combinational slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder slice per clock, LSB first, registered carry.
// Result and carry-out update only on the edge that enters DONE.
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             fa_s, fa_co;

    full_adder u_slice (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (c_q),
        .sum   (fa_s),
        .carry (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = {fa_s, acc_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Counter parks at zero so it never runs past WIDTH-1.
                    cnt_d   = '0;
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    carry_d = fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed + random checks of serial_adder at WIDTH=16 and an exhaustive sweep at WIDTH=4.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st16 = 1'b0, st4 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        c16 = 1'b0, c4 = 1'b0;
    logic        busy16, done16, carry16, busy4, done4, carry4;
    logic [15:0] sum16;
    logic [3:0]  sum4;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_start(st16), .in_a(a16), .in_b(b16), .in_c(c16),
        .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_start(st4), .in_a(a4), .in_b(b4), .in_c(c4),
        .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until done16; every cycle before done checks busy and that the old result is held.
    task automatic wait16(input logic [16:0] hold, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (!done16) begin
                check("busy16", 32'(busy16), 32'd1);
                check("hold16", {15'd0, carry16, sum16}, 32'(hold));
            end
        end while (!done16 && cyc < 40);
    endtask

    // Accept an op on the next edge, wait for done, check latency and result.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic corrupt, inout logic [16:0] last);
        int cyc;
        logic [16:0] exp;
        exp = 17'(a) + 17'(b) + 17'(c);
        a16 = a; b16 = b; c16 = c; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        if (corrupt) begin a16 = '0; b16 = '0; c16 = 1'b0; end
        check({tag, "_busy1"}, 32'(busy16), 32'd1);
        wait16(last, cyc);
        check({tag, "_lat"}, 32'(cyc + 1), 32'd17);
        check({tag, "_res"}, {15'd0, carry16, sum16}, 32'(exp));
        tick();
        check({tag, "_idle"}, {30'd0, busy16, done16}, 32'd0);
        last = exp;
    endtask

    initial begin
        logic [16:0] last;
        int cyc, ndone;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_state", {28'd0, busy16, done16, carry16, busy4}, 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        rst_n = 1'b1;
        tick();
        last = '0;

        op16("t1", 16'd3, 16'd4, 1'b0, 1'b0, last);
        op16("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, last);
        op16("t3", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, last);

        // Starts during SHIFT and DONE are ignored
        a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        repeat (5) tick();
        st16 = 1'b1;
        tick();
        st16 = 1'b0;
        wait16(last, cyc);
        check("t4_lat", 32'(cyc), 32'd10);
        check("t4_res", {15'd0, carry16, sum16}, 32'h2345);
        last = 17'h02345;
        st16 = 1'b1;
        tick();
        st16 = 1'b0;
        check("t4_done_start_lost", {30'd0, busy16, done16}, 32'd0);
        tick();
        check("t4_still_idle", 32'(busy16), 32'd0);
        op16("t4b", 16'h0F0F, 16'h7070, 1'b1, 1'b0, last);

        // Reset during SHIFT
        a16 = 16'h00FF; b16 = 16'h0001; c16 = 1'b0; st16 = 1'b1;
        tick();
        st16 = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst", {15'd0, carry16, sum16}, 32'd0);
        check("t5_rst_flags", {30'd0, busy16, done16}, 32'd0);
        ndone = 0;
        repeat (20) begin
            tick();
            if (done16) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        last = '0;

        // Random operands
        for (int i = 0; i < 8; i++)
            op16("rnd", 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, last);

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); c4 = 1'(c); st4 = 1'b1;
                    tick();
                    st4 = 1'b0;
                    cyc = 1;
                    while (!done4 && cyc < 20) begin
                        tick();
                        cyc++;
                    end
                    check("w4_lat", 32'(cyc), 32'd5);
                    check("w4_res", {27'd0, carry4, sum4}, 32'(a + b + c));
                    tick();
                    check("w4_pulse", 32'(done4), 32'd0);
                end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
